// File: rtl/mm_ram_param_if.sv
// Core fetch/LSU and host configuration bus of mm_ram_param.
// Latency: none (wires only).
// Backpressure: the grant signals stall the core; the config port is never stalled.
interface mm_ram_param_if;
    logic        conf_sel;
    logic        conf_rden;
    logic        conf_wren;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;
    logic        conf_rvalid;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [5:0]  data_atop_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;

    modport slave (
        input  conf_sel, conf_rden, conf_wren, conf_addr, conf_wdata,
        output conf_rdata, conf_rvalid,
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport master (
        output conf_sel, conf_rden, conf_wren, conf_addr, conf_wdata,
        input  conf_rdata, conf_rvalid,
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_atop_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/mm_ram_param.sv
// Split instr/data RAM with host config port; atomic RMW on the data port when DATA_AMO_EN is defined.
// Latency: every granted request or config read answers exactly RD_LAT cycles later.
// Backpressure: gnt low while conf_sel=1 and during the AMO write cycle; responses cannot be stalled.
module mm_ram_param #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mm_ram_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_imem [DEPTH];
    logic [31:0] r_dmem [DEPTH];

    logic              w_idle;
    logic              w_i_gnt, w_d_gnt, w_d_load, w_d_st;
    logic              w_conf_rd, w_conf_wr, w_c_bank;
    logic [ADDR_W-1:0] w_i_idx, w_d_idx, w_c_idx;
    logic              w_amo_go, w_amo_wr;
    logic [31:0]       w_amo_res;
    logic [ADDR_W-1:0] w_amo_idx;
    logic              w_unused;

    assign w_i_idx   = bus.instr_addr_i[ADDR_W+1:2];
    assign w_d_idx   = bus.data_addr_i[ADDR_W+1:2];
    assign w_c_idx   = bus.conf_addr[ADDR_W-1:0];
    assign w_c_bank  = bus.conf_addr[ADDR_W];
    assign w_conf_rd = bus.conf_sel & bus.conf_rden;
    assign w_conf_wr = bus.conf_sel & bus.conf_wren;

    assign w_i_gnt = bus.instr_req_i & ~bus.conf_sel;
    assign w_d_gnt = bus.data_req_i & ~bus.conf_sel & w_idle;
    assign w_d_load = w_d_gnt & (w_amo_go | ~bus.data_we_i);
    assign w_d_st   = w_d_gnt & ~w_amo_go & bus.data_we_i;

    assign bus.instr_gnt_o = w_i_gnt;
    assign bus.data_gnt_o  = w_d_gnt;

`ifdef DATA_AMO_EN
    typedef enum logic {ST_IDLE, ST_RMW} state_t;
    state_t            r_state, w_state_nxt;
    logic [31:0]       r_amo_old, r_amo_opd;
    logic [4:0]        r_amo_fn;
    logic [ADDR_W-1:0] r_amo_idx;

    assign w_amo_go  = w_d_gnt & bus.data_atop_i[5];
    assign w_idle    = (r_state == ST_IDLE);
    assign w_amo_idx = r_amo_idx;
    assign w_unused  = ^{bus.conf_addr[31:ADDR_W+1], bus.instr_addr_i[31:ADDR_W+2],
                         bus.instr_addr_i[1:0], bus.data_addr_i[31:ADDR_W+2], bus.data_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_amo_old <= '0;
            r_amo_opd <= '0;
            r_amo_fn  <= '0;
            r_amo_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_amo_go) begin
                r_amo_old <= r_dmem[w_d_idx];
                r_amo_opd <= bus.data_wdata_i;
                r_amo_fn  <= bus.data_atop_i[4:0];
                r_amo_idx <= w_d_idx;
            end
        end
    end

    // Unsupported funct5 codes still spend the RMW cycle but write nothing.
    always_comb begin
        w_state_nxt = r_state;
        w_amo_wr    = 1'b0;
        w_amo_res   = '0;
        case (r_state)
            ST_IDLE: if (w_amo_go) w_state_nxt = ST_RMW;
            ST_RMW: begin
                w_state_nxt = ST_IDLE;
                w_amo_wr    = 1'b1;
                case (r_amo_fn)
                    5'b00001: w_amo_res = r_amo_opd;
                    5'b00000: w_amo_res = r_amo_old + r_amo_opd;
                    5'b00100: w_amo_res = r_amo_old ^ r_amo_opd;
                    5'b01100: w_amo_res = r_amo_old & r_amo_opd;
                    5'b01000: w_amo_res = r_amo_old | r_amo_opd;
                    default:  w_amo_wr  = 1'b0;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
`else
    assign w_amo_go  = 1'b0;
    assign w_amo_wr  = 1'b0;
    assign w_amo_res = '0;
    assign w_amo_idx = '0;
    assign w_idle    = 1'b1;
    assign w_unused  = ^{bus.conf_addr[31:ADDR_W+1], bus.instr_addr_i[31:ADDR_W+2],
                         bus.instr_addr_i[1:0], bus.data_addr_i[31:ADDR_W+2], bus.data_addr_i[1:0],
                         bus.data_atop_i};
`endif

    // Core writes come last so they win over a config write to the same word.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (w_conf_wr && !w_c_bank) r_imem[w_c_idx] <= bus.conf_wdata;
            if (w_conf_wr && w_c_bank)  r_dmem[w_c_idx] <= bus.conf_wdata;
            for (int b = 0; b < 4; b++) begin
                if (w_d_st && bus.data_be_i[b]) r_dmem[w_d_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
            end
            if (w_amo_wr) r_dmem[w_amo_idx] <= w_amo_res;
        end
    end

    logic [RD_LAT-1:0] r_i_vld, r_d_vld, r_c_vld;
    logic [31:0]       r_i_dat [RD_LAT];
    logic [31:0]       r_d_dat [RD_LAT];
    logic [31:0]       r_c_dat [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_i_vld <= '0;
            r_d_vld <= '0;
            r_c_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_i_dat[k] <= '0;
                r_d_dat[k] <= '0;
                r_c_dat[k] <= '0;
            end
        end else begin
            r_i_vld[0] <= w_i_gnt;
            r_d_vld[0] <= w_d_gnt;
            r_c_vld[0] <= w_conf_rd;
            r_i_dat[0] <= w_i_gnt ? r_imem[w_i_idx] : '0;
            r_d_dat[0] <= w_d_load ? r_dmem[w_d_idx] : '0;
            r_c_dat[0] <= !w_conf_rd ? '0 : (w_c_bank ? r_dmem[w_c_idx] : r_imem[w_c_idx]);
            for (int k = 1; k < RD_LAT; k++) begin
                r_i_vld[k] <= r_i_vld[k-1];
                r_d_vld[k] <= r_d_vld[k-1];
                r_c_vld[k] <= r_c_vld[k-1];
                r_i_dat[k] <= r_i_dat[k-1];
                r_d_dat[k] <= r_d_dat[k-1];
                r_c_dat[k] <= r_c_dat[k-1];
            end
        end
    end

    assign bus.instr_rvalid_o = r_i_vld[RD_LAT-1];
    assign bus.instr_rdata_o  = r_i_dat[RD_LAT-1];
    assign bus.data_rvalid_o  = r_d_vld[RD_LAT-1];
    assign bus.data_rdata_o   = r_d_dat[RD_LAT-1];
    assign bus.conf_rvalid    = r_c_vld[RD_LAT-1];
    assign bus.conf_rdata     = r_c_dat[RD_LAT-1];
endmodule
